// File: rtl/float_mul_pipe_norm_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : float_mul_pipe_norm_stage                                  |
// | Description : Normalize/round stage of the single-precision multiplier,  |
// |               with a one-entry valid/ready output buffer.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module float_mul_pipe_norm_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  n_rm,
   input  logic        n_sign,
   input  logic [9:0]  n_exp10,
   input  logic        n_is_inf_nan,
   input  logic [22:0] n_inf_nan_frac,
   input  logic [47:0] n_z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] s,
   output logic        flag_ovf,
   output logic        flag_unf,
   output logic        flag_inx
);

   localparam logic [1:0]  c_RM_RNE  = 2'b00;
   localparam logic [1:0]  c_RM_RZ   = 2'b01;
   localparam logic [1:0]  c_RM_RD   = 2'b10;
   localparam logic [30:0] c_MAG_INF = 31'h7F800000;
   localparam logic [30:0] c_MAG_MAX = 31'h7F7FFFFF;

   logic        valid_q;
   logic [31:0] s_q;
   logic        ovf_q, unf_q, inx_q;

   logic [22:0] frac_n;
   logic        g, st, inc;
   logic [23:0] frac_sum;
   logic [9:0]  e_n, e_r;
   logic [31:0] s_d;
   logic        ovf_d, unf_d, inx_d;
   logic        accept;

   assign in_ready  = !valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = valid_q;
   assign s         = s_q;
   assign flag_ovf  = ovf_q;
   assign flag_unf  = unf_q;
   assign flag_inx  = inx_q;

   always_comb begin
      frac_n = n_z[47] ? n_z[46:24] : n_z[45:23];
      g      = n_z[47] ? n_z[23]    : n_z[22];
      st     = n_z[47] ? |n_z[22:0] : |n_z[21:0];
      e_n    = n_exp10 + {9'd0, n_z[47]};

      case (n_rm)
         c_RM_RNE: inc = g && (st || frac_n[0]);
         c_RM_RZ:  inc = 1'b0;
         c_RM_RD:  inc = n_sign && (g || st);
         default:  inc = !n_sign && (g || st);
      endcase

      // A carry out of the fraction renormalizes to 1.0 x 2^(e+1)
      frac_sum = {1'b0, frac_n} + {23'd0, inc};
      e_r      = e_n + {9'd0, frac_sum[23]};

      s_d   = {n_sign, e_r[7:0], frac_sum[22:0]};
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = g || st;

      if (n_is_inf_nan) begin
         s_d   = {n_sign, 8'hFF, n_inf_nan_frac};
         inx_d = 1'b0;
      end else if (n_z == 48'd0) begin
         s_d   = {n_sign, 31'd0};
         inx_d = 1'b0;
      end else if ($signed(e_r) >= 10'sd255) begin
         ovf_d = 1'b1;
         inx_d = 1'b1;
         case (n_rm)
            c_RM_RNE: s_d = {n_sign, c_MAG_INF};
            c_RM_RZ:  s_d = {n_sign, c_MAG_MAX};
            c_RM_RD:  s_d = {n_sign, n_sign ? c_MAG_INF : c_MAG_MAX};
            default:  s_d = {n_sign, n_sign ? c_MAG_MAX : c_MAG_INF};
         endcase
      end else if ($signed(e_r) <= 10'sd0) begin
         s_d   = {n_sign, 31'd0};
         unf_d = 1'b1;
         inx_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         s_q     <= 32'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         inx_q   <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         s_q     <= s_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         inx_q   <= inx_d;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_float_mul_pipe_norm_stage.sv
`default_nettype none
// Testbench for float_mul_pipe_norm_stage: directed corner cases plus a
// randomized handshake run scored against an arithmetic reference model.
module tb_float_mul_pipe_norm_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  n_rm;
   logic        n_sign;
   logic [9:0]  n_exp10;
   logic        n_is_inf_nan;
   logic [22:0] n_inf_nan_frac;
   logic [47:0] n_z;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s;
   logic        flag_ovf, flag_unf, flag_inx;

   int total = 0;
   int bad   = 0;
   int exp_int;
   logic [34:0] sb_q[$];

   always #5 clk = ~clk;

   float_mul_pipe_norm_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .n_rm(n_rm), .n_sign(n_sign), .n_exp10(n_exp10),
      .n_is_inf_nan(n_is_inf_nan), .n_inf_nan_frac(n_inf_nan_frac), .n_z(n_z),
      .out_valid(out_valid), .out_ready(out_ready), .s(s),
      .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   // Reference: {s, ovf, unf, inx} from integer rounding of the significand
   function automatic logic [34:0] ref_mul(input logic [1:0] rm, input logic sg, input int ex,
                                           input logic inf, input logic [22:0] ifr, input logic [47:0] z);
      int          sh, e;
      logic [47:0] kept, rem, half;
      logic        up;
      logic [30:0] inf_mag, max_mag;
      inf_mag = 31'h7F800000;
      max_mag = 31'h7F7FFFFF;
      if (inf) return {sg, 8'hFF, ifr, 3'b000};
      if (z == 48'd0) return {sg, 31'd0, 3'b000};
      sh   = z[47] ? 24 : 23;
      e    = ex + (z[47] ? 1 : 0);
      kept = z >> sh;
      rem  = z - (kept << sh);
      half = 48'd1 << (sh - 1);
      case (rm)
         2'b00:   up = (rem > half) || (rem == half && kept[0]);
         2'b01:   up = 1'b0;
         2'b10:   up = sg && (rem != 0);
         default: up = !sg && (rem != 0);
      endcase
      kept = kept + {47'd0, up};
      if (kept == 48'h1000000) begin
         kept = 48'h800000;
         e    = e + 1;
      end
      if (e >= 255) begin
         case (rm)
            2'b00:   return {sg, inf_mag, 3'b101};
            2'b01:   return {sg, max_mag, 3'b101};
            2'b10:   return {sg, sg ? inf_mag : max_mag, 3'b101};
            default: return {sg, sg ? max_mag : inf_mag, 3'b101};
         endcase
      end
      if (e <= 0) return {sg, 31'd0, 3'b011};
      return {sg, e[7:0], kept[22:0], 2'b00, rem != 0};
   endfunction

   task automatic set_in(input logic [1:0] rm, input logic sg, input int ex,
                         input logic inf, input logic [22:0] ifr, input logic [47:0] z);
      n_rm = rm; n_sign = sg; exp_int = ex; n_exp10 = ex[9:0];
      n_is_inf_nan = inf; n_inf_nan_frac = ifr; n_z = z;
   endtask

   // Accept one bundle, check the registered result, then pop it
   task automatic dir(input string tag, input logic [31:0] exp_s, input logic [2:0] exp_f);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, " valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, " s"}, {32'd0, s}, {32'd0, exp_s});
      chk({tag, " flags"}, {61'd0, flag_ovf, flag_unf, flag_inx}, {61'd0, exp_f});
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " drained"}, {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
   endtask

   // One scoreboarded cycle: inputs were set before the call
   task automatic step();
      logic [34:0] e;
      @(negedge clk);
      chk("occupancy", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
      if (out_valid && out_ready && sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("rand result", {29'd0, s, flag_ovf, flag_unf, flag_inx}, {29'd0, e});
      end
      if (in_valid && in_ready)
         sb_q.push_back(ref_mul(n_rm, n_sign, exp_int, n_is_inf_nan, n_inf_nan_frac, n_z));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [47:0] z;
      int          k;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_in(2'b00, 1'b0, 0, 1'b0, 23'd0, 48'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset valid", {63'd0, out_valid}, 64'd0);
      chk("reset s", {32'd0, s}, 64'd0);
      chk("reset flags", {61'd0, flag_ovf, flag_unf, flag_inx}, 64'd0);
      chk("reset in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;

      set_in(2'b00, 1'b0, 128, 1'b0, 23'd0, 48'h600000_000000); dir("1.5x2", 32'h40400000, 3'b000);
      set_in(2'b00, 1'b0, 127, 1'b0, 23'd0, 48'h7FFFFF_C00000); dir("carry rne", 32'h40000000, 3'b001);
      set_in(2'b01, 1'b0, 127, 1'b0, 23'd0, 48'h7FFFFF_C00000); dir("carry rz", 32'h3FFFFFFF, 3'b001);
      set_in(2'b00, 1'b0, 254, 1'b0, 23'd0, 48'h800000_000000); dir("ovf rne", 32'h7F800000, 3'b101);
      set_in(2'b01, 1'b0, 254, 1'b0, 23'd0, 48'h800000_000000); dir("ovf rz", 32'h7F7FFFFF, 3'b101);
      set_in(2'b11, 1'b1, 254, 1'b0, 23'd0, 48'h800000_000000); dir("ovf ru neg", 32'hFF7FFFFF, 3'b101);
      set_in(2'b10, 1'b1, 254, 1'b0, 23'd0, 48'h800000_000000); dir("ovf rd neg", 32'hFF800000, 3'b101);
      set_in(2'b00, 1'b0, -1, 1'b0, 23'd0, 48'h400000_000000);  dir("underflow", 32'h00000000, 3'b011);
      set_in(2'b00, 1'b1, 5, 1'b0, 23'd0, 48'd0);               dir("zero", 32'h80000000, 3'b000);
      set_in(2'b00, 1'b0, 0, 1'b1, 23'h400000, 48'h123);        dir("nan", 32'h7FC00000, 3'b000);
      set_in(2'b11, 1'b0, 127, 1'b0, 23'd0, 48'h400000_000001); dir("ru sticky", 32'h3F800001, 3'b001);
      set_in(2'b10, 1'b1, 127, 1'b0, 23'd0, 48'h400000_000001); dir("rd sticky", 32'hBF800001, 3'b001);

      // Back-pressure: hold A, refuse B, then pop A and take B together
      out_ready = 1'b0; in_valid = 1'b1;
      set_in(2'b00, 1'b0, 128, 1'b0, 23'd0, 48'h600000_000000);
      @(posedge clk); #1;
      set_in(2'b00, 1'b0, 127, 1'b0, 23'd0, 48'h7FFFFF_C00000);
      @(negedge clk);
      chk("bp in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp held s", {32'd0, s}, 64'h40400000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp still held", {32'd0, s}, 64'h40400000);
      chk("bp still valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp pop ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("bp second s", {32'd0, s}, 64'h40000000);
      chk("bp second valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst hold valid", {63'd0, out_valid}, 64'd0);
      chk("rst hold s", {32'd0, s}, 64'd0);
      @(posedge clk); #1;

      sb_q.delete();
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         z = {$urandom, $urandom};
         if ($urandom % 2) z[47] = 1'b1;
         else z[47:46] = 2'b01;
         k = $urandom % 16;
         if (k == 0) z[22:0] = 23'd0;
         if (k == 1) z[45:23] = 23'h7FFFFF;
         if (k == 2) z = 48'd0;
         set_in(2'($urandom), 1'($urandom), $urandom_range(350, 0) - 60,
                ($urandom % 20) == 0, 23'($urandom), z);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      chk("scoreboard empty", {32'd0, 32'(sb_q.size())}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/float_mul_pipe_norm_stage.md
Name: float_mul_pipe_norm_stage

Overview:
- Final normalize/round stage of the pipelined single-precision multiplier.
- Consumes the n_* bundle produced by the alignment-to-normalize pipeline register and emits the IEEE-754 32-bit product.
- Carries a valid/ready handshake so downstream back-pressure stalls the multiplier pipeline.
- Rounds per rm, detects overflow/underflow/inexact, and registers the result, plus flags, in a one-entry output buffer.

Parameters:
- None. Single-precision widths are fixed: 10-bit exponent, 23-bit fraction, 48-bit product.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  n_* bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- n_rm  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward -inf, 11 toward +inf.
- n_sign  in  1  product sign.
- n_exp10  in  10  biased exponent before normalization, two's complement (ea+eb-127).
- n_is_inf_nan  in  1  special result (inf or NaN).
- n_inf_nan_frac  in  23  fraction to emit when n_is_inf_nan.
- n_z  in  48  raw significand product; bit 47 or bit 46 is the leading one for normal operands.
- out_valid  out  1  s/flags valid.
- out_ready  in  1  downstream accepts.
- s  out  32  product {sign, exp8, frac23}.
- flag_ovf  out  1  overflow.
- flag_unf  out  1  underflow (flushed to zero).
- flag_inx  out  1  inexact.

Behaviour:
- Reset: clk and rst_n are the only clock/reset. Reset is synchronous, active-low: on a clk edge with rst_n=0, out_valid=0, s=32'h0, all flags=0.
  - Reset mid-operation discards any held result.
  - in_ready is 1 in the cycle after reset.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept on in_valid & in_ready. The registered result appears in the next cycle (latency 1) with out_valid=1.
  - Held result is stable while out_valid & !out_ready.
  - Simultaneous pop and push is allowed, giving full throughput of one result per cycle.
  - out_valid clears after a pop with no push.
- Normalize:
  - If n_z[47]: frac=n_z[46:24], g=n_z[23], st=|n_z[22:0], e=n_exp10+1.
  - Else: frac=n_z[45:23], g=n_z[22], st=|n_z[21:0], e=n_exp10.
  - All exponent arithmetic is 10-bit signed.
- Round increment:
  - RNE: g&(st|frac[0]).
  - RZ: 0.
  - RD: sign&(g|st).
  - RU: !sign&(g|st).
- Rounding carry: frac=7FFFFF plus increment gives frac=0, e=e+1. Overflow is checked after rounding.
- flag_inx = g|st for finite, non-flushed results.
- Special case has priority: if n_is_inf_nan, s={sign,8'hFF,n_inf_nan_frac} and all flags are 0.
- Overflow when e ≥ 255 (signed): flag_ovf=1, flag_inx=1. Result by mode:
  - RNE: ±inf.
  - RZ: ±7F7FFFFF.
  - RD: +7F7FFFFF, or -inf (FF800000) if negative.
  - RU: +inf, or FF7FFFFF if negative.
- Underflow when e ≤ 0 (signed): s={sign,31'h0}, flag_unf=1, flag_inx=1. Denormals are not produced.
- Zero product: n_z=0 with !n_is_inf_nan gives s={sign,31'h0} and no flags. This takes priority over underflow.

Test Plan:
- 1.5×2.0: n_z=48'h600000_000000, n_exp10=128, rm=00 → s=32'h40400000, no flags, out_valid one cycle after accept.
- Rounding carry: n_z=48'h7FFFFF_C00000, n_exp10=127. rm=00 → s=32'h40000000, flag_inx=1. rm=01 → s=32'h3FFFFFFF.
- Overflow: n_z=48'h800000_000000, n_exp10=254.
  - sign=0: rm=00 → 32'h7F800000; rm=01 → 32'h7F7FFFFF; flag_ovf=1 in both.
  - sign=1, rm=11 → 32'hFF7FFFFF.
- Underflow: n_exp10=10'h3FF, n_z=48'h400000_000000 → s=32'h00000000, flag_unf=1. Zero: n_z=0 → s=0, flags 0.
- NaN: n_is_inf_nan=1, n_inf_nan_frac=23'h400000 → s=32'h7FC00000.
- Back-pressure: out_ready=0 with two in_valid beats → first result held stable, in_ready=0, second bundle not accepted.
  - out_ready=1 → first result popped and second accepted the same cycle.
  - rst_n=0 while holding → out_valid=0 next edge.
